// File: rtl/mesh_nic_pkg.sv
// Shared constants for the mesh network interface: register map and packet layout.
package nic_pkg;

   localparam logic [1:0] NIC_IN_DATA  = 2'd0;
   localparam logic [1:0] NIC_IN_STAT  = 2'd1;
   localparam logic [1:0] NIC_OUT_DATA = 2'd2;
   localparam logic [1:0] NIC_OUT_STAT = 2'd3;

   localparam int NIC_DATA_WIDTH = 64;
   // The VC bit rides in the packet MSB.
   localparam int NIC_VC_BIT     = NIC_DATA_WIDTH - 1;

endpackage

// File: rtl/mesh_nic_if.sv
// Processor register port plus router PE-port handshake of one mesh node.
interface mesh_nic_if #(
   parameter int DATA_WIDTH = 64
);
   logic [1:0]            addr;
   logic [DATA_WIDTH-1:0] d_in;
   logic [DATA_WIDTH-1:0] d_out;
   logic                  nicEn;
   logic                  nicWrEn;
   logic                  net_so;
   logic                  net_ro;
   logic [DATA_WIDTH-1:0] net_do;
   logic                  net_si;
   logic                  net_ri;
   logic [DATA_WIDTH-1:0] net_di;
   logic                  net_polarity;

   // master: processor + router side; slave: the NIC itself
   modport master (
      output addr, d_in, nicEn, nicWrEn, net_ro, net_si, net_di, net_polarity,
      input  d_out, net_so, net_do, net_ri
   );
   modport slave (
      input  addr, d_in, nicEn, nicWrEn, net_ro, net_si, net_di, net_polarity,
      output d_out, net_so, net_do, net_ri
   );
endinterface

// File: rtl/mesh_nic_buffer.sv
// Single-entry packet slot with full flag; load takes priority over clear.
module nic_buffer #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] ld_data,
   output logic         full,
   output logic [W-1:0] data
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         full <= 1'b0;
         data <= '0;
      end else if (load) begin
         full <= 1'b1;
         data <= ld_data;
      end else if (clear) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/mesh_nic.sv
// Mesh NIC: register-mapped single-entry in/out channels to the router PE port,
// injection gated by the mesh-wide polarity against the packet VC bit.
module mesh_nic
   import nic_pkg::*;
#(
   parameter int DATA_WIDTH = NIC_DATA_WIDTH,
   parameter int VC_BIT     = DATA_WIDTH - 1
) (
   input logic       clk,
   input logic       reset,
   mesh_nic_if.slave bus
);

   logic                  rd_en, wr_en;
   logic                  obuf_full, ibuf_full;
   logic [DATA_WIDTH-1:0] obuf, ibuf;
   logic                  obuf_load, ibuf_load, ibuf_clear;
   logic                  send;
   logic [DATA_WIDTH-1:0] d_out_q;

   assign rd_en = bus.nicEn & ~bus.nicWrEn;
   assign wr_en = bus.nicEn &  bus.nicWrEn;

   // A packet may only leave on the polarity phase matching its VC.
   assign send = obuf_full & bus.net_ro & (bus.net_polarity == obuf[VC_BIT]);

   // Load only when empty, so a write colliding with a transfer is dropped.
   assign obuf_load  = wr_en & (bus.addr == NIC_OUT_DATA) & ~obuf_full;
   assign ibuf_load  = bus.net_si & ~ibuf_full;
   assign ibuf_clear = rd_en & (bus.addr == NIC_IN_DATA) & ibuf_full;

   nic_buffer #(.W(DATA_WIDTH)) u_obuf (
      .clk     (clk),
      .reset   (reset),
      .load    (obuf_load),
      .clear   (send),
      .ld_data (bus.d_in),
      .full    (obuf_full),
      .data    (obuf)
   );

   nic_buffer #(.W(DATA_WIDTH)) u_ibuf (
      .clk     (clk),
      .reset   (reset),
      .load    (ibuf_load),
      .clear   (ibuf_clear),
      .ld_data (bus.net_di),
      .full    (ibuf_full),
      .data    (ibuf)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         d_out_q <= '0;
      end else if (rd_en) begin
         case (bus.addr)
            NIC_IN_DATA:  d_out_q <= ibuf;
            NIC_IN_STAT:  d_out_q <= {{(DATA_WIDTH-1){1'b0}}, ibuf_full};
            NIC_OUT_DATA: d_out_q <= obuf;
            NIC_OUT_STAT: d_out_q <= {{(DATA_WIDTH-1){1'b0}}, obuf_full};
            default:      d_out_q <= d_out_q;
         endcase
      end
   end

   assign bus.net_so = send;
   assign bus.net_do = obuf;
   assign bus.net_ri = ~ibuf_full;
   assign bus.d_out  = d_out_q;

endmodule

// File: tb/tb_mesh_nic.sv
// Bench for mesh_nic: queue-based channel model checked every cycle, plus directed literals.
module tb_mesh_nic;

   localparam int DW = 64;
   localparam int VC = DW - 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mesh_nic_if #(.DATA_WIDTH(DW)) bus ();

   mesh_nic #(.DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      string         name;
      logic [DW-1:0] act;
      logic [DW-1:0] exp;
   } lit_t;
   lit_t lit_q[$];

   // Model: each channel is a queue of at most one packet; registers seen by the
   // processor are the last packet written/accepted and the last read result.
   logic [DW-1:0] out_q[$];
   logic [DW-1:0] in_q[$];
   logic [DW-1:0] last_out, last_in, exp_dout;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q.delete();
         in_q.delete();
         last_out = '0;
         last_in  = '0;
         exp_dout = '0;
      end else begin
         automatic bit ofull = (out_q.size() != 0);
         automatic bit ifull = (in_q.size() != 0);
         automatic bit rd    = bus.nicEn && !bus.nicWrEn;
         automatic bit wr    = bus.nicEn && bus.nicWrEn;
         if (rd) begin
            case (bus.addr)
               2'd0: exp_dout = last_in;
               2'd1: exp_dout = DW'(ifull);
               2'd2: exp_dout = last_out;
               default: exp_dout = DW'(ofull);
            endcase
            if (bus.addr == 2'd0 && ifull) void'(in_q.pop_front());
         end
         if (ofull && bus.net_ro && (bus.net_polarity == out_q[0][VC]))
            void'(out_q.pop_front());
         else if (!ofull && wr && bus.addr == 2'd2) begin
            out_q.push_back(bus.d_in);
            last_out = bus.d_in;
         end
         if (bus.net_si && !ifull) begin
            in_q.push_back(bus.net_di);
            last_in = bus.net_di;
         end
      end
   end

   task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // The single compare process: model vs DUT every cycle, then queued literals.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            automatic bit exp_so = (out_q.size() != 0) && bus.net_ro &&
                                   (bus.net_polarity == last_out[VC]);
            cmp("net_so", DW'(bus.net_so), DW'(exp_so));
            cmp("net_ri", DW'(bus.net_ri), DW'(in_q.size() == 0));
            cmp("net_do", bus.net_do, last_out);
            cmp("d_out",  bus.d_out,  exp_dout);
         end
         while (lit_q.size() != 0) begin
            automatic lit_t l = lit_q.pop_front();
            cmp(l.name, l.act, l.exp);
         end
      end
   end

   task automatic lit(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      lit_t l;
      l.name = name; l.act = act; l.exp = exp;
      lit_q.push_back(l);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      bus.nicEn = 1'b0; bus.nicWrEn = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [DW-1:0] d);
      bus.nicEn = 1'b1; bus.nicWrEn = 1'b1; bus.addr = a; bus.d_in = d;
      tick(); idle();
   endtask

   task automatic rd(input logic [1:0] a);
      bus.nicEn = 1'b1; bus.nicWrEn = 1'b0; bus.addr = a;
      tick(); idle();
   endtask

   initial begin
      reset = 1'b0;
      bus.addr = '0; bus.d_in = '0; bus.nicEn = 1'b0; bus.nicWrEn = 1'b0;
      bus.net_ro = 1'b0; bus.net_si = 1'b0; bus.net_di = '0; bus.net_polarity = 1'b0;
      tick(); tick();
      lit("rst_so", DW'(bus.net_so), 0);
      lit("rst_ri", DW'(bus.net_ri), 1);
      lit("rst_do", bus.net_do, 0);
      lit("rst_dout", bus.d_out, 0);
      reset = 1'b1;
      tick();

      // VC0 packet leaves on the edge after load when polarity is 0.
      bus.net_ro = 1'b1; bus.net_polarity = 1'b0;
      wr(2'd2, 64'h0000_0000_0000_00A5);
      lit("t1_so", DW'(bus.net_so), 1);
      lit("t1_do", bus.net_do, 64'hA5);
      tick();
      rd(2'd3);
      lit("t1_ostat", bus.d_out, 0);

      // VC1 packet waits for polarity 1.
      wr(2'd2, 64'h8000_0000_0000_0001);
      lit("t2_so_wait", DW'(bus.net_so), 0);
      tick();
      lit("t2_so_still", DW'(bus.net_so), 0);
      bus.net_polarity = 1'b1; #1;
      lit("t2_so_go", DW'(bus.net_so), 1);
      tick();
      bus.net_polarity = 1'b0;

      // Write while full is dropped.
      bus.net_ro = 1'b0;
      wr(2'd2, 64'h1111);
      wr(2'd2, 64'hDEAD);
      rd(2'd2);
      lit("t3_obuf", bus.d_out, 64'h1111);
      rd(2'd3);
      lit("t3_ostat", bus.d_out, 1);
      bus.net_ro = 1'b1;
      tick();
      rd(2'd3);
      lit("t3_drained", bus.d_out, 0);

      // Ejection and read-back.
      bus.net_si = 1'b1; bus.net_di = 64'h1234;
      tick();
      bus.net_si = 1'b0;
      lit("t4_ri", DW'(bus.net_ri), 0);
      rd(2'd1);
      lit("t4_istat", bus.d_out, 1);
      rd(2'd0);
      lit("t4_idata", bus.d_out, 64'h1234);
      lit("t4_ri_back", DW'(bus.net_ri), 1);

      // Held net_si while full does not overwrite; accepted once space frees.
      bus.net_si = 1'b1; bus.net_di = 64'hAAAA;
      tick();
      bus.net_di = 64'h5678;
      tick(); tick();
      lit("t5_ri_full", DW'(bus.net_ri), 0);
      rd(2'd0);
      lit("t5_first", bus.d_out, 64'hAAAA);
      lit("t5_ri_free", DW'(bus.net_ri), 1);
      tick();
      lit("t5_refill", DW'(bus.net_ri), 0);
      bus.net_si = 1'b0;
      rd(2'd0);
      lit("t5_second", bus.d_out, 64'h5678);
      rd(2'd0);
      lit("t5_stale", bus.d_out, 64'h5678);
      wr(2'd0, 64'hFFFF);
      wr(2'd1, 64'hFFFF);
      wr(2'd3, 64'hFFFF);
      rd(2'd1);
      lit("t5_istat0", bus.d_out, 0);
      rd(2'd3);
      lit("t5_ostat0", bus.d_out, 0);

      // Asynchronous reset with both buffers full and a send in flight.
      bus.net_si = 1'b1; bus.net_di = 64'h77;
      tick();
      bus.net_si = 1'b0;
      rd(2'd1);
      wr(2'd2, 64'h42);
      lit("t6_pre_so", DW'(bus.net_so), 1);
      lit("t6_pre_dout", bus.d_out, 1);
      #1 reset = 1'b0;
      #1;
      lit("t6_so", DW'(bus.net_so), 0);
      lit("t6_ri", DW'(bus.net_ri), 1);
      lit("t6_dout", bus.d_out, 0);
      lit("t6_do", bus.net_do, 0);
      tick(); tick();
      reset = 1'b1;
      tick(); tick();
      lit("t6_after_ri", DW'(bus.net_ri), 1);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
